dec_3x8_seq: RTL and testbench
==============================

Name: dec_3x8_seq

Overview:
- Sequenced 3-to-8 decoder. It is the output-side counterpart of the 8-to-3 priority encoder.
- Accepts 3-bit line indices through a valid/ready handshake and buffers them in a small FIFO.
- Drives the selected line of an active-low 8-bit output bus, one index at a time.
- Each index holds its line low for a fixed pulse width, followed by an idle gap.
- Used to regenerate active-low request/strobe lines from encoded indices.

Parameters:
- HOLD, 4: cycles a decoded line is held low (legal 1..255).
- GAP, 1: idle cycles, with Y all ones, between consecutive pulses (legal 1..255).
- DEPTH, 4: index FIFO depth (power of two, 2..16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  active-low enable. 0 = operate; 1 = disabled, flush, outputs idle.
- I  input  3  line index to decode.
- I_valid  input  1  I is valid this cycle.
- I_ready  output  1  block can accept I this cycle.
- Y  output  8  registered active-low one-hot output; 8'hFF = idle.
- busy  output  1  pulse in progress, gap in progress, or FIFO non-empty.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - Y=8'hFF, FSM=IDLE, FIFO empty, level=0, busy=0, I_ready=0.
  - Hold/gap counter cleared.
  - After release, I_ready follows the rule below from the first clk edge.
- Handshake:
  - I_ready = (en==0) && (level<DEPTH). Combinational from registered state.
  - Push occurs at a clock edge when I_valid && I_ready.
  - No pass-through: a push into a full FIFO is impossible even if a pop happens in the same cycle.
  - Push and pop in the same cycle are allowed when not full; level is unchanged.
  - I_valid while I_ready=0 is ignored; the index is dropped and the source must hold it.
- FSM states: IDLE, DRIVE, GAP.
  - IDLE: if en==0 and level>0, pop head index n, set Y = ~(8'b1<<n), load counter=HOLD-1, go to DRIVE. Otherwise Y=8'hFF.
  - DRIVE: Y held. If counter==0, set Y=8'hFF, load counter=GAP-1, go to GAP. Otherwise decrement.
  - GAP: Y=8'hFF. If counter==0: if level>0, pop and enter DRIVE as in IDLE, back-to-back with no extra IDLE cycle; else go to IDLE. Otherwise decrement.
- Timing:
  - Index pushed at edge k into an empty, IDLE block: Y goes low after edge k+1, i.e. 1-cycle latency.
  - Y stays low for exactly HOLD cycles, then stays high for exactly GAP cycles.
  - Pulse period with a full queue = HOLD+GAP cycles.
- Exactly one Y bit is low in DRIVE. Y is never multi-hot and never has a glitch-driven bit (registered output).
- Ordering: indices are decoded strictly in FIFO order. Duplicate indices produce separate pulses separated by GAP.
- Disable, en=1, sampled at the clock edge, any state:
  - Next edge: Y=8'hFF, FSM=IDLE, FIFO flushed (level=0), counter cleared.
  - I_ready=0 while en=1.
  - A pulse in progress is truncated, not completed.
- Re-enable: en 1->0 resumes from IDLE with an empty FIFO. The first push follows normal latency.
- Mid-operation reset: same as power-on reset. Y returns to 8'hFF asynchronously, with no wait for clk.
- busy = (state!=IDLE) || (level!=0).

Test Plan:
1. Reset then idle: rst_n=0 with I_valid=1 -> Y=8'hFF, I_ready=0, level=0. After release with en=0 -> I_ready=1.
2. Single decode, HOLD=4, GAP=1: push I=3'd5 at edge k -> Y=8'b11011111 for edges k+1..k+4 (4 cycles), Y=8'hFF at k+5, busy=0 from k+6.
3. Back-to-back queue: push 0,7,2 on consecutive cycles -> pulses 8'b11111110, 8'b01111111, 8'b11111011, each 4 cycles low with exactly 1 idle cycle between. Level peaks at 2.
4. Full FIFO, DEPTH=4: hold I_valid=1 with indices 1..6 -> I_ready drops when level=4. Index 6 is accepted only after a pop. All six pulses appear in order 1..6.
5. Disable mid-pulse: during index 3 pulse cycle 2 with 2 entries queued, drive en=1 -> next edge Y=8'hFF, level=0, I_ready=0. After en=0, pushing 4 gives Y=8'b11101111 with 1-cycle latency.
6. Async reset mid-pulse: assert rst_n=0 between clk edges while Y=8'b10111111 -> Y=8'hFF immediately, level=0. No stale pulse after release.

Source files
------------

// File: rtl/dec_3x8_seq.sv
// Sequenced 3-to-8 decoder: buffers 3-bit indices in a FIFO and drives each one
// as an active-low pulse of HOLD cycles on Y, followed by GAP idle cycles.
module dec_3x8_seq #(
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [2:0]                   I,
  input  logic                         I_valid,
  output logic                         I_ready,
  output logic [7:0]                   Y,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [1:0]                   dbg_state
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  // Handshake: a push happens at a rising edge when I_valid && I_ready; I_ready
  // depends only on registered state and en, never on I_valid.
  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      y_q, y_d;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic            live_q, live_d;
  logic [2:0]      mem_q [DEPTH];
  logic [2:0]      mem_d [DEPTH];

  logic            push;
  logic            pop;
  logic [2:0]      head;
  logic [7:0]      y_start;

  assign head    = mem_q[rd_q];
  assign y_start = ~(8'd1 << head);
  assign I_ready = live_q && !en && (lvl_q < LW'(DEPTH));
  assign push    = I_valid && I_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    pop     = 1'b0;
    live_d  = 1'b1;
    if (en) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      y_d     = 8'hFF;
    end else begin
      case (state_q)
        S_IDLE: begin
          y_d = 8'hFF;
          if (lvl_q != '0) begin
            pop     = 1'b1;
            y_d     = y_start;
            cnt_d   = 8'(HOLD - 1);
            state_d = S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt_q == 8'd0) begin
            y_d     = 8'hFF;
            cnt_d   = 8'(GAP - 1);
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_GAP: begin
          y_d = 8'hFF;
          if (cnt_q == 8'd0) begin
            // Chain straight into the next pulse so the period is HOLD+GAP.
            if (lvl_q != '0) begin
              pop     = 1'b1;
              y_d     = y_start;
              cnt_d   = 8'(HOLD - 1);
              state_d = S_DRIVE;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          y_d     = 8'hFF;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    lvl_d = lvl_q;
    if (en) begin
      rd_d  = '0;
      wr_d  = '0;
      lvl_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = I;
        wr_d        = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      lvl_d = lvl_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      y_q     <= 8'hFF;
      lvl_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      live_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      lvl_q   <= lvl_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      live_q  <= live_d;
      mem_q   <= mem_d;
    end
  end

  assign Y         = y_q;
  assign level     = lvl_q;
  assign busy      = (state_q != S_IDLE) || (lvl_q != '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dec_3x8_seq.sv
// Bench for dec_3x8_seq: directed pushes, a schedule-based reference model checked
// every cycle, and literal expectations for latency, ordering, disable and reset.
module tb_dec_3x8_seq;

  localparam int HOLD  = 4;
  localparam int GAP   = 1;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] I = 3'd0;
  logic       I_valid = 1'b0;
  logic       I_ready;
  logic [7:0] Y;
  logic       busy;
  logic [2:0] level;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  dec_3x8_seq #(.HOLD(HOLD), .GAP(GAP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .I(I), .I_valid(I_valid),
    .I_ready(I_ready), .Y(Y), .busy(busy), .level(level), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending indices plus a queue of Y values still to be shown.
  logic [2:0] m_q[$];
  logic [7:0] sched_q[$];
  logic [7:0] m_y = 8'hFF;
  bit         m_in_pulse = 0;
  bit         m_live = 0;
  logic [7:0] seen_q[$];
  logic [7:0] prev_y = 8'hFF;
  int         peak = 0;

  always begin : model_and_compare
    bit push_ok;
    int n;
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      sched_q.delete();
      m_y = 8'hFF;
      m_in_pulse = 0;
      m_live = 0;
    end else begin
      push_ok = m_live && !en && I_valid && (m_q.size() < DEPTH);
      if (en) begin
        m_q.delete();
        sched_q.delete();
        m_y = 8'hFF;
        m_in_pulse = 0;
      end else begin
        if (sched_q.size() == 0 && m_q.size() != 0) begin
          n = int'(m_q.pop_front());
          for (int h = 0; h < HOLD; h++) sched_q.push_back(~(8'd1 << n));
          for (int g = 0; g < GAP; g++) sched_q.push_back(8'hFF);
        end
        if (sched_q.size() != 0) begin
          m_y = sched_q.pop_front();
          m_in_pulse = 1;
        end else begin
          m_y = 8'hFF;
          m_in_pulse = 0;
        end
        if (push_ok) m_q.push_back(I);
      end
      m_live = 1;
    end
    #1;
    check("cyc_y", Y, m_y);
    check("cyc_ready", {7'd0, I_ready}, {7'd0, (m_live && !en && m_q.size() < DEPTH)});
    check("cyc_level", {5'd0, level}, 8'(m_q.size()));
    check("cyc_busy", {7'd0, busy}, {7'd0, (m_in_pulse || m_q.size() != 0)});
    if (Y !== 8'hFF) check("cyc_onehot", 8'($countones(~Y)), 8'd1);
    if (Y !== 8'hFF && prev_y === 8'hFF) seen_q.push_back(Y);
    prev_y = Y;
    if (int'(level) > peak) peak = int'(level);
  end

  // Driver tasks
  task automatic push(input logic [2:0] idx);
    bit ok;
    ok = 0;
    I = idx;
    I_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (I_ready) ok = 1;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout: index %0d never accepted", idx);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, budget);
    end
  endtask

  initial begin
    // 1. Reset with I_valid asserted
    rst_n = 1'b0; en = 1'b0; I_valid = 1'b1; I = 3'd2;
    repeat (2) @(negedge clk);
    check("rst_y", Y, 8'hFF);
    check("rst_ready", {7'd0, I_ready}, 8'd0);
    check("rst_level", {5'd0, level}, 8'd0);
    check("rst_state", {6'd0, dbg_state}, 8'd0);
    rst_n = 1'b1; I_valid = 1'b0;
    @(negedge clk);
    check("rel_ready", {7'd0, I_ready}, 8'd1);

    // 2. Single decode of index 5
    push(3'd5); I_valid = 1'b0;
    check("t2_latency_y", Y, 8'hFF);
    check("t2_level", {5'd0, level}, 8'd1);
    for (int c = 0; c < HOLD; c++) begin
      @(negedge clk);
      check("t2_low", Y, 8'b1101_1111);
    end
    @(negedge clk);
    check("t2_gap_y", Y, 8'hFF);
    check("t2_gap_busy", {7'd0, busy}, 8'd1);
    @(negedge clk);
    check("t2_idle_busy", {7'd0, busy}, 8'd0);

    // 3. Back-to-back queue 0,7,2
    seen_q.delete(); peak = 0;
    push(3'd0); push(3'd7); push(3'd2); I_valid = 1'b0;
    wait_idle(100);
    check("t3_peak", 8'(peak), 8'd2);
    check("t3_count", 8'(seen_q.size()), 8'd3);
    if (seen_q.size() == 3) begin
      check("t3_p0", seen_q[0], 8'b1111_1110);
      check("t3_p1", seen_q[1], 8'b0111_1111);
      check("t3_p2", seen_q[2], 8'b1111_1011);
    end

    // 4. Fill the FIFO with 1..6
    seen_q.delete();
    for (int k = 1; k <= 5; k++) push(3'(k));
    check("t4_full_level", {5'd0, level}, 8'd4);
    check("t4_full_ready", {7'd0, I_ready}, 8'd0);
    push(3'd6); I_valid = 1'b0;
    wait_idle(200);
    check("t4_count", 8'(seen_q.size()), 8'd6);
    if (seen_q.size() == 6) begin
      check("t4_p1", seen_q[0], 8'hFD);
      check("t4_p2", seen_q[1], 8'hFB);
      check("t4_p3", seen_q[2], 8'hF7);
      check("t4_p4", seen_q[3], 8'hEF);
      check("t4_p5", seen_q[4], 8'hDF);
      check("t4_p6", seen_q[5], 8'hBF);
    end

    // 5. Disable during the second low cycle of index 3 with two queued
    push(3'd3); push(3'd6); push(3'd0);
    check("t5_mid_y", Y, 8'hF7);
    check("t5_mid_level", {5'd0, level}, 8'd2);
    en = 1'b1; I_valid = 1'b1; I = 3'd7;
    @(negedge clk);
    check("t5_dis_y", Y, 8'hFF);
    check("t5_dis_level", {5'd0, level}, 8'd0);
    check("t5_dis_ready", {7'd0, I_ready}, 8'd0);
    @(negedge clk);
    check("t5_dis_busy", {7'd0, busy}, 8'd0);
    en = 1'b0; I_valid = 1'b0;
    @(negedge clk);
    push(3'd4); I_valid = 1'b0;
    check("t5_re_latency", Y, 8'hFF);
    @(negedge clk);
    check("t5_re_y", Y, 8'b1110_1111);
    wait_idle(100);

    // 6. Asynchronous reset in the middle of a pulse
    push(3'd6); push(3'd1); I_valid = 1'b0;
    check("t6_pre_y", Y, 8'b1011_1111);
    check("t6_pre_level", {5'd0, level}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_y", Y, 8'hFF);
    check("t6_async_level", {5'd0, level}, 8'd0);
    check("t6_async_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t6_no_stale_y", Y, 8'hFF);
    check("t6_no_stale_busy", {7'd0, busy}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
